uparc_imuldiv_seq: RTL and testbench
====================================

Name: uparc_imuldiv_seq

Overview:
Sequencer for the CPU's integer multiply/divide resource. It accepts the multiply/divide op field issued by the decode stage for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO. It runs iterative radix-2 shift-add multiply and restoring divide over 32 iterations and owns the HI/LO registers. It raises a pipeline stall whenever an issued op needs a busy unit.

Parameters:
ITER, 32, number of iteration cycles per MUL/DIV; fixed to data width, not intended to be overridden.

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
i_imuldiv_op  input  `UPARC_IMDOP_WIDTH  op from decode; `UPARC_IMDOP_* encoding, IDLE = no op
i_rs_val  input  `UPARC_DATA_WIDTH  rs operand; multiplicand/dividend; MTHI/MTLO data
i_rt_val  input  `UPARC_DATA_WIDTH  rt operand; multiplier/divisor
i_core_stall  input  1  OR of exec/mem/fetch/wait stalls from other sources
i_nullify  input  1  presented op is cancelled this cycle
o_stall  output  1  imuldiv stall request to the control unit
o_busy  output  1  an iterative operation is in flight
o_result  output  `UPARC_DATA_WIDTH  HI for MFHI, LO for MFLO, else 0

Behaviour:
- Reset is nrst, asynchronous, active-low; clock is clk. Reset values: state IDLE, HI = 0, LO = 0, counter = 0, o_busy = 0, o_stall = 0, o_result = 0.
- Reset mid-operation aborts the operation immediately. HI/LO are cleared and no partial result is committed.
- accept = (op != IDLE) && !o_busy && !i_core_stall && !i_nullify. With i_core_stall or i_nullify high, nothing is latched; decode re-presents the op.
- o_stall = o_busy && (op != IDLE) && !i_nullify. This is combinational and independent of i_core_stall.
- States:
  - IDLE -> MUL on accepted MUL/MULU.
  - IDLE -> DIV on accepted DIV/DIVU.
  - MUL/DIV -> FIX when the counter reaches 0.
  - FIX -> IDLE unconditionally.
- MTHI/MTLO/MFHI/MFLO never leave IDLE.
- Start (accept edge):
  - Latch |rs| and |rt| for signed ops (two's-complement absolute value, 32-bit unsigned; 0x80000000 stays 0x80000000). Latch raw values for unsigned ops.
  - Latch neg_q = rs[31]^rt[31] and neg_r = rs[31] for signed ops; both are 0 for unsigned ops.
  - Counter = ITER-1.
- MUL iteration: 64-bit accumulator. If multiplier bit0 = 1, add the multiplicand into the upper half. Then shift the {carry, acc} right by 1.
- DIV iteration: restoring division.
  - Shift {rem, quot} left by 1.
  - If rem >= divisor, subtract and set quot bit0.
  - The 33-bit compare avoids overflow.
- Counter decrements once per iteration cycle; 32 iteration cycles in total.
- FIX (one cycle): apply sign fixups, then write HI/LO at the FIX->IDLE edge.
  - MUL: {HI, LO} = neg_q ? -prod64 : prod64.
  - DIV: LO = neg_q ? -quot : quot; HI = neg_r ? -rem : rem.
- Divide by zero: no exception, full latency. LO = 0xFFFFFFFF and HI = i_rs_val as latched raw (signed or unsigned).
- Signed overflow case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Timing: accept at edge E0. o_busy is high for 33 cycles (32 iterations + FIX). HI/LO hold their new values and o_busy = 0 from the cycle after edge E33.
- MTHI/MTLO on accept: HI or LO <= i_rs_val at that edge; no busy period.
- MFHI/MFLO while idle: o_result = HI/LO combinationally in the same cycle. It reflects the value committed at the most recent edge, with no bypass of a same-cycle MT write.
- Any op other than IDLE presented while busy stalls until o_busy falls. This covers MUL/DIV (structural) and MF/MT (HI/LO hazard). On the first non-busy cycle the op is accepted or read normally.
- o_result = 0 whenever the op is not MFHI/MFLO or o_busy = 1.
- i_nullify while busy does not abort the in-flight operation; it only suppresses o_stall for the presented op.
- Simultaneous i_core_stall during iteration does not pause the iterations.

Test Plan:
- MULTU 7 × 6, then MFLO/MFHI -> 33 busy cycles, LO = 42, HI = 0. A MFLO issued at E1 stalls exactly 32 cycles, then returns 42.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001. MULT 0xFFFFFFFF × 2 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU 100 / 0 -> LO = 0xFFFFFFFF, HI = 100, busy 33 cycles, no error flag.
- MTLO 0x1234 with i_core_stall = 1 for 3 cycles -> LO unchanged until the stall drops, then LO = 0x1234. A MULT presented with i_nullify = 1 -> no busy, HI/LO unchanged.
- MULT issued, nrst pulsed low at iteration 10 -> o_busy = 0 and HI = LO = 0 asynchronously. A following MFHI returns 0 with no stall.

Source files
------------

// File: rtl/uparc_imuldiv_seq.sv
// Integer multiply/divide sequencer: owns HI/LO, runs 32-step shift-add multiply
// and restoring divide, and raises a stall when an issued op finds the unit busy.
`ifndef UPARC_DATA_WIDTH
`define UPARC_DATA_WIDTH 32
`endif
`ifndef UPARC_IMDOP_WIDTH
`define UPARC_IMDOP_WIDTH 4
`endif
`ifndef UPARC_IMDOP_IDLE
`define UPARC_IMDOP_IDLE  4'd0
`define UPARC_IMDOP_MULT  4'd1
`define UPARC_IMDOP_MULTU 4'd2
`define UPARC_IMDOP_DIV   4'd3
`define UPARC_IMDOP_DIVU  4'd4
`define UPARC_IMDOP_MFHI  4'd5
`define UPARC_IMDOP_MFLO  4'd6
`define UPARC_IMDOP_MTHI  4'd7
`define UPARC_IMDOP_MTLO  4'd8
`endif

// state | meaning
// IDLE  | no iterative op; MT/MF ops serviced here
// MUL   | shift-add multiply iteration
// DIV   | restoring divide iteration
// FIX   | sign fixup and HI/LO commit
module uparc_imuldiv_seq #(
  parameter int ITER = 32
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [`UPARC_IMDOP_WIDTH-1:0] i_imuldiv_op,
  input  logic [`UPARC_DATA_WIDTH-1:0]  i_rs_val,
  input  logic [`UPARC_DATA_WIDTH-1:0]  i_rt_val,
  input  logic                          i_core_stall,
  input  logic                          i_nullify,
  output logic                          o_stall,
  output logic                          o_busy,
  output logic [`UPARC_DATA_WIDTH-1:0]  o_result
);
  localparam int DW = `UPARC_DATA_WIDTH;
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   hi, lo, opnd_b;
  logic [2*DW-1:0] acc;
  logic            neg_q, neg_r, is_div, div_zero, busy;

  logic            op_idle, accept, is_signed;
  logic [DW-1:0]   rs_abs, rt_abs;
  logic [DW:0]     mul_sum, rem_sh, rem_sub;
  logic [2*DW-1:0] mul_next, div_next, prod_fix;

  assign op_idle   = (i_imuldiv_op == `UPARC_IMDOP_IDLE);
  assign accept    = !op_idle && !busy && !i_core_stall && !i_nullify;
  assign is_signed = (i_imuldiv_op == `UPARC_IMDOP_MULT) || (i_imuldiv_op == `UPARC_IMDOP_DIV);
  assign rs_abs    = (is_signed && i_rs_val[DW-1]) ? -i_rs_val : i_rs_val;
  assign rt_abs    = (is_signed && i_rt_val[DW-1]) ? -i_rt_val : i_rt_val;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd_b} : {(DW+1){1'b0}});
  assign mul_next = {mul_sum, acc[DW-1:1]};

  // Divide: acc = {remainder, quotient/dividend}; 33-bit compare avoids overflow
  assign rem_sh   = {acc[2*DW-1:DW], acc[DW-1]};
  assign rem_sub  = rem_sh - {1'b0, opnd_b};
  assign div_next = (rem_sh >= {1'b0, opnd_b}) ? {rem_sub[DW-1:0], acc[DW-2:0], 1'b1}
                                               : {rem_sh[DW-1:0],  acc[DW-2:0], 1'b0};

  assign prod_fix = neg_q ? -acc : acc;

  assign o_busy  = busy;
  assign o_stall = busy && !op_idle && !i_nullify;

  always_comb begin
    o_result = '0;
    if (!busy && i_imuldiv_op == `UPARC_IMDOP_MFHI) o_result = hi;
    else if (!busy && i_imuldiv_op == `UPARC_IMDOP_MFLO) o_result = lo;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      opnd_b   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (i_imuldiv_op)
              `UPARC_IMDOP_MULT, `UPARC_IMDOP_MULTU: begin
                state  <= S_MUL;
                busy   <= 1'b1;
                cnt    <= CW'(ITER-1);
                acc    <= {{DW{1'b0}}, rt_abs};
                opnd_b <= rs_abs;
                neg_q  <= is_signed && (i_rs_val[DW-1] ^ i_rt_val[DW-1]);
                neg_r  <= is_signed && i_rs_val[DW-1];
                is_div <= 1'b0;
              end
              `UPARC_IMDOP_DIV, `UPARC_IMDOP_DIVU: begin
                state    <= S_DIV;
                busy     <= 1'b1;
                cnt      <= CW'(ITER-1);
                acc      <= {{DW{1'b0}}, rs_abs};
                opnd_b   <= rt_abs;
                neg_q    <= is_signed && (i_rs_val[DW-1] ^ i_rt_val[DW-1]);
                neg_r    <= is_signed && i_rs_val[DW-1];
                is_div   <= 1'b1;
                div_zero <= (i_rt_val == '0);
              end
              `UPARC_IMDOP_MTHI: hi <= i_rs_val;
              `UPARC_IMDOP_MTLO: lo <= i_rs_val;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          acc <= (state == S_DIV) ? div_next : mul_next;
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          if (is_div) begin
            // Divide by zero reports all-ones quotient; remainder fixup restores the dividend
            lo <= div_zero ? {DW{1'b1}} : (neg_q ? -acc[DW-1:0] : acc[DW-1:0]);
            hi <= neg_r ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];
          end else begin
            hi <= prod_fix[2*DW-1:DW];
            lo <= prod_fix[DW-1:0];
          end
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uparc_imuldiv_seq.sv
// Directed bench for uparc_imuldiv_seq: hand-computed HI/LO, latency and stall checks.
module tb_uparc_imuldiv_seq;
  localparam logic [3:0] OP_IDLE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  imd_op;
  logic [31:0] rs, rt;
  logic        core_stall, nullify;
  logic        o_stall, o_busy;
  logic [31:0] o_result;

  int n_pass = 0;
  int n_total = 0;

  uparc_imuldiv_seq dut (
    .clk(clk), .nrst(nrst), .i_imuldiv_op(imd_op), .i_rs_val(rs), .i_rt_val(rt),
    .i_core_stall(core_stall), .i_nullify(nullify),
    .o_stall(o_stall), .o_busy(o_busy), .o_result(o_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    imd_op = OP_MFHI; #1;
    check({tag, " HI"}, o_result, ehi);
    imd_op = OP_MFLO; #1;
    check({tag, " LO"}, o_result, elo);
    imd_op = OP_IDLE;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int nb;
    @(negedge clk); imd_op = op; rs = a; rt = b;
    @(posedge clk); #1; imd_op = OP_IDLE;
    nb = 0;
    while (o_busy && nb < 60) begin nb++; @(posedge clk); #1; end
    check({tag, " busy cycles"}, 32'(nb), 32'd33);
    read_hilo(tag, ehi, elo);
  endtask

  initial begin
    int nb, ns;
    nrst = 1'b0; imd_op = OP_MFLO; rs = '0; rt = '0; core_stall = 1'b0; nullify = 1'b0;
    #12;
    check("reset busy", {31'b0, o_busy}, 32'd0);
    check("reset stall", {31'b0, o_stall}, 32'd0);
    check("reset result", o_result, 32'd0);
    imd_op = OP_IDLE;
    @(negedge clk); nrst = 1'b1;

    // MULTU 7*6 with a MFLO issued one cycle after accept
    @(negedge clk); imd_op = OP_MULTU; rs = 32'd7; rt = 32'd6;
    @(posedge clk); #1; imd_op = OP_IDLE;
    nb = 0; ns = 0;
    for (int k = 0; k < 60 && o_busy; k++) begin
      nb++;
      if (o_stall) ns++;
      @(posedge clk); #1;
      if (k == 0) imd_op = OP_MFLO;
    end
    check("multu busy cycles", 32'(nb), 32'd33);
    check("mflo stall cycles", 32'(ns), 32'd32);
    check("mflo stall after", {31'b0, o_stall}, 32'd0);
    check("mflo after multu", o_result, 32'd42);
    imd_op = OP_MFHI; #1;
    check("mfhi after multu", o_result, 32'd0);
    imd_op = OP_IDLE;

    run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -1*2", OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mult -3*-5", OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu 100/0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // MTLO held off by core stall for three edges
    @(negedge clk); imd_op = OP_MTLO; rs = 32'h1234; core_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      imd_op = OP_MFLO; #1;
      check("mtlo under core stall", o_result, 32'hFFFF_FFFF);
      imd_op = OP_MTLO;
    end
    check("mtlo no imuldiv stall", {31'b0, o_stall}, 32'd0);
    @(negedge clk); core_stall = 1'b0;
    @(posedge clk); #1; imd_op = OP_MFLO; #1;
    check("mtlo committed", o_result, 32'h1234);

    @(negedge clk); imd_op = OP_MTHI; rs = 32'hABCD;
    @(posedge clk); #1;
    read_hilo("mthi", 32'hABCD, 32'h1234);

    // Nullified MULT must not start
    @(negedge clk); imd_op = OP_MULT; rs = 32'd3; rt = 32'd3; nullify = 1'b1;
    @(posedge clk); #1; imd_op = OP_IDLE; nullify = 1'b0;
    check("nullified mult busy", {31'b0, o_busy}, 32'd0);
    read_hilo("nullified mult", 32'hABCD, 32'h1234);

    // MULT aborted by reset during iteration 10
    @(negedge clk); imd_op = OP_MULT; rs = 32'd5; rt = 32'd5;
    @(posedge clk); #1; imd_op = OP_IDLE;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
    check("mid-op busy", {31'b0, o_busy}, 32'd1);
    imd_op = OP_MFHI; core_stall = 1'b1; #1;
    check("stall ignores core stall", {31'b0, o_stall}, 32'd1);
    check("busy result zero", o_result, 32'd0);
    nullify = 1'b1; #1;
    check("nullify hides stall", {31'b0, o_stall}, 32'd0);
    nullify = 1'b0; core_stall = 1'b0; imd_op = OP_IDLE;
    #1; nrst = 1'b0; #1;
    check("abort busy", {31'b0, o_busy}, 32'd0);
    read_hilo("abort", 32'h0, 32'h0);
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1; imd_op = OP_MFHI; #1;
    check("post-reset mfhi stall", {31'b0, o_stall}, 32'd0);
    check("post-reset mfhi", o_result, 32'd0);
    @(posedge clk); #1;
    check("post-reset idle", {31'b0, o_busy}, 32'd0);
    imd_op = OP_IDLE;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
